packetfilter_forwarder: RTL and testbench

Reader-side companion to `packetfilter_core`: drains an accepted packet from the core's forwarder port and presents it as an AXI4-Stream master. It claims a ready packet via the `rdy_for_fwd`/`rdy_for_fwd_ack` handshake. It then issues pipelined word reads with credit-based flow control, streams the returned words with correct `tkeep`/`tlast`, and releases the buffer with a one-cycle `fwd_done` pulse. It sits between the core and the downstream egress logic.

---
 rtl/packetfilter_forwarder.sv | 149 ++++++++++++++
 tb/tb_packetfilter_forwarder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/packetfilter_forwarder.sv
// packetfilter_forwarder: claims a ready packet from the core, reads it out with
// credit-limited pipelined word reads and streams it as an AXI4-Stream master.
module packetfilter_forwarder #(
   parameter  int PACKET_MEM_BYTES   = 2048,
   parameter  int PACKMEM_DATA_WIDTH = 64,
   parameter  int PLEN_WIDTH         = 32,
   parameter  int FIFO_DEPTH         = 4,
   localparam int PACKMEM_ADDR_WIDTH = $clog2(PACKET_MEM_BYTES) - 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rdy_for_fwd,
   output logic                          rdy_for_fwd_ack,
   input  logic [PLEN_WIDTH-1:0]         fwd_byte_len,
   output logic [PACKMEM_ADDR_WIDTH-1:0] fwd_addr,
   output logic                          fwd_rd_en,
   input  logic [PACKMEM_DATA_WIDTH-1:0] fwd_rd_data,
   input  logic                          fwd_rd_data_vld,
   output logic                          fwd_done,
   output logic [PACKMEM_DATA_WIDTH-1:0] m_axis_tdata,
   output logic [7:0]                    m_axis_tkeep,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready
);
   localparam int LEN_W = PACKMEM_ADDR_WIDTH + 4;  // wide enough to hold PACKET_MEM_BYTES
   localparam int NW_W  = PACKMEM_ADDR_WIDTH + 1;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_CLAIM, S_READ, S_DRAIN, S_DONE} state_t;

   state_t                        r_state;
   logic                          r_ack, r_done;
   logic [NW_W-1:0]               r_nwords, r_issue, r_beat;
   logic [2:0]                    r_rem;
   logic [CW-1:0]                 r_inflight, r_fcnt;
   logic [PW-1:0]                 r_wp, r_rp;
   logic [PACKMEM_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

   logic [LEN_W-1:0] w_len, w_len_rnd;
   logic [NW_W-1:0]  w_nwords;
   logic [CW:0]      w_occ;
   logic [7:0]       w_keep_tail;
   logic             w_push, w_pop, w_last, w_rd_en, w_vld_ret;

   assign w_len     = (fwd_byte_len > PLEN_WIDTH'(PACKET_MEM_BYTES)) ?
                      LEN_W'(PACKET_MEM_BYTES) : fwd_byte_len[LEN_W-1:0];
   assign w_len_rnd = w_len + LEN_W'(7);
   assign w_nwords  = NW_W'(w_len_rnd >> 3);

   assign m_axis_tvalid = (r_fcnt != '0);
   assign w_pop     = m_axis_tvalid && m_axis_tready;
   assign w_push    = fwd_rd_data_vld && (r_fcnt != DEPTH_C);
   assign w_vld_ret = fwd_rd_data_vld && (r_inflight != '0);
   // A word leaving the FIFO this cycle frees its slot for a read issued now,
   // which keeps one beat per cycle when the depth covers the read latency.
   assign w_occ     = {1'b0, r_inflight} + {1'b0, r_fcnt} - {{CW{1'b0}}, w_pop};
   assign w_rd_en   = (r_state == S_READ) && (w_occ < {1'b0, DEPTH_C});
   assign w_last    = (r_beat == r_nwords - NW_W'(1));
   assign w_keep_tail = (r_rem == 3'd0) ? 8'hFF : ~(8'hFF >> r_rem);

   assign fwd_rd_en       = w_rd_en;
   assign fwd_addr        = r_issue[PACKMEM_ADDR_WIDTH-1:0];
   assign rdy_for_fwd_ack = r_ack;
   assign fwd_done        = r_done;
   assign m_axis_tdata    = m_axis_tvalid ? r_mem[r_rp] : '0;
   assign m_axis_tkeep    = !m_axis_tvalid ? 8'h00 : (w_last ? w_keep_tail : 8'hFF);
   assign m_axis_tlast    = m_axis_tvalid && w_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wp       <= '0;
         r_rp       <= '0;
         r_fcnt     <= '0;
         r_inflight <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + PW'(1);
         if (w_pop)  r_rp <= r_rp + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_fcnt <= r_fcnt + CW'(1);
            2'b01:   r_fcnt <= r_fcnt - CW'(1);
            default: ;
         endcase
         case ({w_rd_en, w_vld_ret})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= fwd_rd_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_ack    <= 1'b0;
         r_done   <= 1'b0;
         r_nwords <= '0;
         r_rem    <= '0;
         r_issue  <= '0;
         r_beat   <= '0;
      end else begin
         if (w_pop) r_beat <= r_beat + NW_W'(1);
         case (r_state)
            S_IDLE: begin
               if (rdy_for_fwd) begin
                  r_state <= S_CLAIM;
                  r_ack   <= 1'b1;
               end
            end
            S_CLAIM: begin
               r_ack    <= 1'b0;
               r_nwords <= w_nwords;
               r_rem    <= w_len[2:0];
               r_issue  <= '0;
               r_beat   <= '0;
               if (w_len == '0) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_READ;
               end
            end
            S_READ: begin
               if (w_rd_en) begin
                  r_issue <= r_issue + NW_W'(1);
                  if (r_issue == r_nwords - NW_W'(1)) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_pop && w_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_packetfilter_forwarder.sv
// Scoreboard bench for packetfilter_forwarder: a latency-programmable memory model
// answers reads, a monitor checks every beat, read address and the credit limit.
module tb_packetfilter_forwarder;
   logic        clk, rst, rdy_for_fwd, rdy_for_fwd_ack, fwd_rd_en, fwd_rd_data_vld, fwd_done;
   logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;
   logic [31:0] fwd_byte_len;
   logic [7:0]  fwd_addr, m_axis_tkeep;
   logic [63:0] fwd_rd_data, m_axis_tdata;

   typedef struct packed {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
   typedef struct packed {int due; logic [63:0] d;} rsp_t;

   beat_t       exp_q[$];
   rsp_t        rsp_q[$];
   logic [63:0] mem [256];
   int checks = 0, errors = 0, cyc = 0, lat = 1;
   int rd_cnt = 0, beats = 0, first_hs_cyc = 0, last_hs_cyc = 0, done_cnt = 0;
   int issued_tot = 0, popped_tot = 0;
   bit tr_alt = 0;

   packetfilter_forwarder dut (
      .clk(clk), .rst(rst), .rdy_for_fwd(rdy_for_fwd), .rdy_for_fwd_ack(rdy_for_fwd_ack),
      .fwd_byte_len(fwd_byte_len), .fwd_addr(fwd_addr), .fwd_rd_en(fwd_rd_en),
      .fwd_rd_data(fwd_rd_data), .fwd_rd_data_vld(fwd_rd_data_vld), .fwd_done(fwd_done),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
   );

   initial begin clk = 1'b0; forever #5 clk = ~clk; end
   initial forever begin @(posedge clk); cyc++; end
   initial begin #500000; $display("FAIL watchdog expired at cycle %0d", cyc); $fatal(1); end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         m_axis_tready = tr_alt ? cyc[0] : 1'b1;
      end
   end

   // memory model: read issued in cycle c returns in cycle c+lat, in order
   initial begin
      rsp_t r;
      fwd_rd_data_vld = 1'b0;
      fwd_rd_data     = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            rsp_q.delete();
            fwd_rd_data_vld = 1'b0;
         end else begin
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
               r = rsp_q.pop_front();
               fwd_rd_data_vld = 1'b1;
               fwd_rd_data     = r.d;
            end else begin
               fwd_rd_data_vld = 1'b0;
               fwd_rd_data     = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            if (fwd_rd_en) begin
               r.due = cyc + lat;
               r.d   = mem[fwd_addr];
               rsp_q.push_back(r);
            end
         end
      end
   end

   initial begin
      beat_t       e;
      bit          stall_prev = 0;
      logic [63:0] prev_d = '0;
      logic [7:0]  prev_k = '0;
      logic        prev_l = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            stall_prev = 0;
         end else begin
            if (fwd_done) done_cnt++;
            if (fwd_rd_en || m_axis_tvalid)
               chk("credit_limit", 64'((issued_tot - popped_tot) <= 4), 64'd1);
            if (stall_prev) begin
               chk("stall_tvalid", m_axis_tvalid, 1);
               chk("stall_tdata", m_axis_tdata, prev_d);
               chk("stall_tkeep", m_axis_tkeep, prev_k);
               chk("stall_tlast", m_axis_tlast, prev_l);
            end
            if (m_axis_tvalid && m_axis_tready) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_beat: got tdata %0h, none expected", m_axis_tdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat_tdata", m_axis_tdata, e.d);
                  chk("beat_tkeep", m_axis_tkeep, e.k);
                  chk("beat_tlast", m_axis_tlast, e.l);
               end
               if (beats == 0) first_hs_cyc = cyc;
               if (m_axis_tlast) last_hs_cyc = cyc;
               beats++;
               popped_tot++;
            end
            if (fwd_rd_en) begin
               chk("rd_addr", fwd_addr, rd_cnt);
               rd_cnt++;
               issued_tot++;
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_d = m_axis_tdata; prev_k = m_axis_tkeep; prev_l = m_axis_tlast;
         end
      end
   end

   task automatic setup(input int nw, input logic [7:0] lastk, input logic [7:0] seed);
      beat_t b;
      for (int i = 0; i < 256; i++) mem[i] = {seed, 24'hC0FFEE, 32'(i) * 32'h0100_0193};
      for (int i = 0; i < nw; i++) begin
         b.d = mem[i];
         b.k = (i == nw - 1) ? lastk : 8'hFF;
         b.l = (i == nw - 1);
         exp_q.push_back(b);
      end
      rd_cnt = 0;
      beats  = 0;
   endtask

   // leaves the caller at #1 after the negedge of cycle N+2
   task automatic claim(input int len);
      int c0, got;
      @(negedge clk);
      c0 = cyc; fwd_byte_len = len; rdy_for_fwd = 1'b1;
      got = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); #1;
         if (rdy_for_fwd_ack) begin got = 1; break; end
      end
      chk("ack_cycle", got ? cyc : 0, c0 + 1);
      rdy_for_fwd = 1'b0;
      @(negedge clk); #1;
      chk("ack_single", rdy_for_fwd_ack, 0);
      if (len != 0) begin
         chk("first_rd_en", fwd_rd_en, 1);
         chk("first_rd_addr", fwd_addr, 0);
      end
   endtask

   task automatic run_pkt(input int len, input int nlat, input bit alt, input int nw,
                          input logic [7:0] lastk, input bit gapless, input logic [7:0] seed);
      int d0, got;
      lat = nlat; tr_alt = alt;
      setup(nw, lastk, seed);
      d0 = done_cnt;
      claim(len);
      if (nw == 0) begin
         chk("zero_done", fwd_done, 1);
         chk("zero_tvalid", m_axis_tvalid, 0);
      end else begin
         got = 0;
         for (int k = 0; k < 3000; k++) begin
            @(negedge clk); #1;
            if (fwd_done) begin got = 1; break; end
         end
         chk("done_cycle", got ? cyc : 0, last_hs_cyc + 1);
         if (gapless) chk("gapless", last_hs_cyc - first_hs_cyc, nw - 1);
      end
      @(negedge clk); #1;
      chk("done_single", fwd_done, 0);
      chk("done_count", done_cnt - d0, 1);
      chk("beat_count", beats, nw);
      chk("read_count", rd_cnt, nw);
      chk("sb_empty", exp_q.size(), 0);
      tr_alt = 0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_tvalid"}, m_axis_tvalid, 0);
      chk({tag, "_tdata"}, m_axis_tdata, 0);
      chk({tag, "_tkeep"}, m_axis_tkeep, 0);
      chk({tag, "_tlast"}, m_axis_tlast, 0);
      chk({tag, "_rd_en"}, fwd_rd_en, 0);
      chk({tag, "_addr"}, fwd_addr, 0);
      chk({tag, "_ack"}, rdy_for_fwd_ack, 0);
      chk({tag, "_done"}, fwd_done, 0);
   endtask

   initial begin
      int d0;
      rst = 1'b0; rdy_for_fwd = 1'b0; fwd_byte_len = '0;
      repeat (3) @(negedge clk);
      #1 chk_outputs_zero("reset");
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);

      run_pkt(20,   1, 0,   3, 8'hF0, 1, 8'h11);
      run_pkt(64,   3, 0,   8, 8'hFF, 1, 8'h22);
      run_pkt(40,   2, 1,   5, 8'hFF, 0, 8'h33);
      run_pkt(0,    1, 0,   0, 8'hFF, 0, 8'h44);
      run_pkt(5000, 1, 0, 256, 8'hFF, 1, 8'h55);

      // asynchronous reset in the middle of an 8-beat packet
      lat = 1; tr_alt = 0;
      setup(8, 8'hFF, 8'h66);
      d0 = done_cnt;
      claim(64);
      for (int k = 0; k < 50; k++) begin
         if (beats >= 2) break;
         @(negedge clk); #1;
      end
      chk("reached_beat2", 64'(beats >= 2), 64'd1);
      #2 rst = 1'b0;
      #1 chk_outputs_zero("midpkt_rst");
      exp_q.delete();
      issued_tot = 0; popped_tot = 0;
      repeat (3) @(negedge clk);
      chk("rst_no_done", done_cnt - d0, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      run_pkt(16, 1, 0, 2, 8'hFF, 1, 8'h77);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
